// File: rtl/accumulator_pkg.sv
// Shared widths and types for the streaming accumulator.
// Saturating arithmetic is selected at build time with ACCUMULATOR_SATURATE_EN.
package accumulator_pkg;

  localparam int DEFAULT_INPUT_WIDTH  = 8;
  localparam int DEFAULT_OUTPUT_WIDTH = 16;

  typedef logic [DEFAULT_INPUT_WIDTH-1:0]  input_data_t;
  typedef logic [DEFAULT_OUTPUT_WIDTH-1:0] sum_t;

endpackage

// File: rtl/valid_ready_register.sv
// One-entry registered valid/ready slice: data and valid come straight from flops,
// and the slice accepts whenever it is empty or its current beat is leaving.
module valid_ready_register #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // The data register keeps its last value once the beat has been consumed.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/valid_ready_accumulator.sv
// Streaming accumulator: each accepted sample is added to a running sum that is emitted
// one cycle later. Define ACCUMULATOR_SATURATE_EN to clamp at all-ones instead of wrapping.
module valid_ready_accumulator
  import accumulator_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [INPUT_WIDTH-1:0]  input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [OUTPUT_WIDTH-1:0] output_data
);

  logic                    accept;
  logic [OUTPUT_WIDTH-1:0] sum_q, sum_d, new_sum;

  assign accept = input_valid && input_ready;

`ifdef ACCUMULATOR_SATURATE_EN
  logic [OUTPUT_WIDTH:0] wide_sum;

  // The extra carry bit tells us the true sum no longer fits, so clamp to all-ones.
  always_comb begin
    wide_sum = {1'b0, sum_q} + (OUTPUT_WIDTH + 1)'(input_data);
    new_sum  = wide_sum[OUTPUT_WIDTH] ? '1 : wide_sum[OUTPUT_WIDTH-1:0];
  end
`else
  always_comb begin
    new_sum = sum_q + OUTPUT_WIDTH'(input_data);
  end
`endif

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = new_sum;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  valid_ready_register #(
    .WIDTH(OUTPUT_WIDTH)
  ) u_out_slice (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (input_valid),
    .in_ready_o (input_ready),
    .in_data_i  (new_sum),
    .out_valid_o(output_valid),
    .out_ready_i(output_ready),
    .out_data_o (output_data)
  );

endmodule

// File: tb/tb_valid_ready_accumulator.sv
// Self-checking bench for valid_ready_accumulator: vector table, hand-written corner
// sequences and randomized streams against a running-sum model.
module tb_valid_ready_accumulator;
  import accumulator_pkg::*;

  logic        clock;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  input_data_t input_data;
  logic        output_valid;
  logic        output_ready;
  sum_t        output_data;

  int errors = 0;
  int checks = 0;

  sum_t modelSum;
  logic modelValid;
  sum_t expQ[$];

  typedef struct {
    logic        rst;
    logic        iv;
    input_data_t id;
    logic        ordy;
    logic        expIrdy;
    logic        expOv;
    sum_t        expOd;
  } vec_t;

  vec_t vecs[14];

  valid_ready_accumulator dut (
    .clock       (clock),
    .reset       (reset),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data (output_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer addition, then wrap or clamp to 16 bits.
  function automatic sum_t nextSum(input sum_t s, input input_data_t d);
    int unsigned t;
    t = int'(s) + int'(d);
`ifdef ACCUMULATOR_SATURATE_EN
    if (t > 65535) t = 65535;
`endif
    return t[15:0];
  endfunction

  task automatic doReset();
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset      = 1'b0;
    modelSum   = '0;
    modelValid = 1'b0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic rst, input logic iv, input input_data_t id, input logic ordy);
    reset        = rst;
    input_valid  = iv;
    input_data   = id;
    output_ready = ordy;
  endtask

  // Streams samples (counter or constant 0xFF) and checks every beat against the model.
  task automatic runStream(input int nBeats, input int readyPct, input bit constFF,
                           input int maxCycles, output int cycles, output sum_t lastBeat);
    int          beats;
    input_data_t ctr;
    logic        acc;
    beats    = 0;
    cycles   = 0;
    ctr      = '0;
    lastBeat = '0;
    doReset();
    while (beats < nBeats && cycles < maxCycles) begin
      applyStimulus(1'b0, 1'b1, constFF ? 8'hFF : ctr, ($urandom_range(0, 99) < readyPct));
      #1;
      checkOutput("stream_valid", output_valid, modelValid);
      checkOutput("stream_ready", input_ready, !modelValid || output_ready);
      if (modelValid && expQ.size() > 0) checkOutput("stream_data", output_data, expQ[0]);
      acc = input_valid && (!modelValid || output_ready);
      if (modelValid && output_ready) begin
        lastBeat = output_data;
        void'(expQ.pop_front());
        beats++;
      end
      if (acc) begin
        modelSum = nextSum(modelSum, input_data);
        expQ.push_back(modelSum);
        ctr++;
      end
      modelValid = acc || (modelValid && !output_ready);
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput("stream_beats_done", beats, nBeats);
    input_valid = 1'b0;
  endtask

  initial begin
    int   cycles;
    sum_t lastBeat;

    vecs[0]  = '{1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 16'h0001};
    vecs[4]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[5]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 16'h0003};
    vecs[6]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 16'h0003};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0003};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0003};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'h0102};
    vecs[10] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 16'h0102};
    vecs[11] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 16'h0005};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0005};

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    doReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d_input_ready", i), input_ready, vecs[i].expIrdy);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_output_valid", i), output_valid, vecs[i].expOv);
      checkOutput($sformatf("vec%0d_output_data", i), output_data, vecs[i].expOd);
    end

    // Backpressure: hold the first beat for five cycles, then transfer and accept together.
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("bp_first_valid", output_valid, 1'b1);
    checkOutput("bp_first_data", output_data, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_stall%0d_ready", i), input_ready, 1'b0);
      checkOutput($sformatf("bp_stall%0d_valid", i), output_valid, 1'b1);
      checkOutput($sformatf("bp_stall%0d_data", i), output_data, 16'h0000);
      @(posedge clock);
      #1;
    end
    output_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", input_ready, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("bp_release_valid", output_valid, 1'b1);
    checkOutput("bp_release_data", output_data, 16'h0001);
    input_valid = 1'b0;

    runStream(256, 100, 1'b0, 1000, cycles, lastBeat);
    checkOutput("counter_last_beat", lastBeat, 16'h7F80);
    checkOutput("counter_cycles", cycles, 257);

    runStream(1000, 80, 1'b0, 10000, cycles, lastBeat);

    runStream(258, 100, 1'b1, 1000, cycles, lastBeat);
`ifdef ACCUMULATOR_SATURATE_EN
    checkOutput("wrap_beat258", lastBeat, 16'hFFFF);
`else
    checkOutput("wrap_beat258", lastBeat, 16'h00FE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/valid_ready_accumulator.md
Name: valid_ready_accumulator

Overview:
Streaming accumulator with valid/ready handshakes on both sides. Every accepted 8-bit input sample is added to a running 16-bit sum, and the updated sum is emitted as one output beat. It sits downstream of a data source such as counter_8bit and upstream of any valid/ready consumer. It is a single-clock, fully registered-output pipeline stage.

Parameters:
INPUT_WIDTH, 8, width of input_data
OUTPUT_WIDTH, 16, width of the running sum and output_data; must be >= INPUT_WIDTH

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
input_valid  input  1  upstream sample valid
input_ready  output  1  block can accept a sample this cycle
input_data  input  INPUT_WIDTH  sample, unsigned
output_valid  output  1  output_data holds a new sum
output_ready  input  1  downstream accepts output this cycle
output_data  output  OUTPUT_WIDTH  running sum including the most recent accepted sample

Behaviour:
- Reset (synchronous, active-high, sampled on rising clock): sum=0, output_valid=0, output_data=0. Reset overrides any handshake in the same cycle. Reset mid-stream discards any pending output beat.
- Input accepted when input_valid && input_ready at a rising edge. Output transfers when output_valid && output_ready.
- input_ready = !output_valid || output_ready. This is combinational and gives full throughput (1 sample/cycle) when downstream is always ready. No combinational path from input_valid to output_valid.
- On accept: new_sum = sum + zero-extended input_data, computed modulo 2^OUTPUT_WIDTH (wrap-around, no flag). At the next edge: sum and output_data <= new_sum, output_valid <= 1.
- Latency: 1 cycle from input acceptance to output_valid.
- Output stable: while output_valid && !output_ready, output_data and output_valid hold unchanged and input_ready=0.
- Output consumed with no new accept in the same cycle: output_valid <= 0. output_data keeps its last value.
- Simultaneous output transfer and input accept: output_valid stays 1 and output_data updates to the new sum. No bubble.
- Exactly one output beat per accepted input, in order. No beats dropped or duplicated.
- First sum includes the first sample: inputs 0,1,2 give outputs 0x0000, 0x0001, 0x0003.

Optional Feature:
Macro ACCUMULATOR_SATURATE_EN.
- Defined: addition saturates at 2^OUTPUT_WIDTH-1. Once the sum reaches all-ones it stays there until reset.
- Undefined (default): modulo wrap-around as specified above.
- Handshake and latency are identical in both modes.

Decomposition:
- Package accumulator_pkg: INPUT_WIDTH/OUTPUT_WIDTH defaults, and typedefs input_data_t and sum_t.
- Sub-module valid_ready_register: generic one-entry registered valid/ready slice holding output_data/output_valid and generating input_ready.
- The top level holds the sum register and adder (with saturate option) and feeds the slice.

Test Plan:
- Reset: hold reset 2 cycles with input_valid=1 -> output_valid=0 and output_data=0x0000 throughout; no sample is consumed.
- counter_8bit source 0,1,2,... with output_ready always 1 -> one beat per cycle after 1-cycle latency; outputs 0x0000,0x0001,0x0003,0x0006; after 256 samples (0..255) output is 0x7F80.
- Random output_ready (~80% high), counter source, 1000 beats -> each beat equals previous beat + next counter value mod 2^16; output_data stable while stalled; all beats complete within 10000 cycles.
- Backpressure: output_ready=0 for 5 cycles after first beat -> input_ready=0, output_data held. On release, the next sample is accepted in the same cycle as the transfer.
- Wrap: 258 samples of 0xFF, ready=1 -> beat 257 = 0xFFFF, beat 258 = 0x00FE. With ACCUMULATOR_SATURATE_EN, beat 258 = 0xFFFF.
- Reset asserted while output_valid=1 and output_ready=0 -> next cycle output_valid=0 and sum=0; the next sample 0x05 yields 0x0005.
